// File: rtl/stim_playback_ctrl_pkg.sv
// Shared types and default widths for the stimulus playback controller.
package stim_playback_ctrl_pkg;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_CNT_W  = 8;
    localparam int DEF_GAP_W  = 8;

    // Output buffer depth; also the read-credit limit.
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        GAP   = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // Words that will still be held after this cycle: buffered words not
    // leaving this cycle plus the read already in flight.
    function automatic logic [2:0] credits_used(input logic [1:0] count,
                                                input logic       pop,
                                                input logic       inflight);
        return 3'(count) - 3'(pop) + 3'(inflight);
    endfunction

endpackage

// File: rtl/stim_playback_ctrl_if.sv
// Valid/ready word stream from the playback controller to its consumer.
interface stim_playback_ctrl_if
    import stim_playback_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic [DATA_W-1:0] out_data;
    logic              out_strobe;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_data, out_strobe, out_last, out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data, out_strobe, out_last, out_valid,
        output out_ready
    );
endinterface

// File: rtl/stim_playback_ctrl_skid_fifo.sv
// Two-entry FIFO holding ROM words between the read port and the stream.
module stim_playback_ctrl_skid_fifo #(
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] entry,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign head    = mem[rd_ptr];

    // Storage, pointers and occupancy; flush empties without touching data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the storage is reset too, because the stream data outputs
            // come straight from the head entry and must read zero in reset.
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments so every register here updates
            // from the pre-edge values, independent of statement order.
            if (do_push) begin
                mem[wr_ptr] <= entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end
endmodule

// File: rtl/stim_playback_ctrl.sv
// Plays a programmed window of a synchronous stimulus ROM onto a valid/ready
// stream: base/length/repeat/gap are latched on start, passes are separated
// by idle gaps, and at most two words are ever buffered or in flight.
module stim_playback_ctrl
    import stim_playback_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int GAP_W  = DEF_GAP_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ADDR_W-1:0]    cfg_base,
    input  logic [ADDR_W-1:0]    cfg_len,
    input  logic [CNT_W-1:0]     cfg_repeat,
    input  logic [GAP_W-1:0]     cfg_gap,
    output logic                 rom_en,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [DATA_W-1:0]    rom_data,
    input  logic                 rom_strobe,
    stim_playback_ctrl_if.master stream,
    output logic                 busy,
    output logic                 done
);
    state_e            state;
    state_e            state_next;

    logic [ADDR_W-1:0] prog_base;
    logic [ADDR_W-1:0] prog_len;
    logic [CNT_W-1:0]  prog_repeat;
    logic [GAP_W-1:0]  prog_gap;

    logic [ADDR_W-1:0] word_cnt;
    logic [CNT_W-1:0]  pass_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              inflight;
    logic              inflight_last;

    logic              load;
    logic              finish;
    logic              last_word;
    logic              final_pass;
    logic              credit_ok;
    logic              pop;
    logic              push;
    logic [1:0]        fifo_count;
    logic [DATA_W+1:0] fifo_head;

    assign last_word  = (word_cnt == prog_len);
    assign final_pass = (prog_repeat != '0) && (pass_cnt == prog_repeat - CNT_W'(1));
    assign pop        = stream.out_valid && stream.out_ready;
    assign credit_ok  = credits_used(fifo_count, pop, inflight) < 3'(FIFO_DEPTH);
    assign push       = inflight && !abort;
    assign rom_addr   = prog_base + word_cnt;
    assign busy       = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, ROM read enable and load/finish strobes; abort wins over all.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves one unassigned and infers a latch.
        state_next = state;
        rom_en     = 1'b0;
        load       = 1'b0;
        finish     = 1'b0;
        if (abort) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        load       = 1'b1;
                        state_next = FETCH;
                    end
                end
                FETCH: begin
                    rom_en = credit_ok;
                    if (credit_ok && last_word) begin
                        if (final_pass) begin
                            state_next = DRAIN;
                        end else if (prog_gap != '0) begin
                            state_next = GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(1)) begin
                        state_next = FETCH;
                    end
                end
                DRAIN: begin
                    if (!inflight && (fifo_count == 2'd1) && pop) begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Program latch, word/pass/gap counters, read tracking and done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prog_base     <= '0;
            prog_len      <= '0;
            prog_repeat   <= '0;
            prog_gap      <= '0;
            word_cnt      <= '0;
            pass_cnt      <= '0;
            gap_cnt       <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done          <= 1'b0;
        end else begin
            inflight      <= rom_en;
            inflight_last <= rom_en && last_word;
            done          <= finish;
            if (load) begin
                prog_base   <= cfg_base;
                prog_len    <= cfg_len;
                prog_repeat <= cfg_repeat;
                prog_gap    <= cfg_gap;
                word_cnt    <= '0;
                pass_cnt    <= '0;
                gap_cnt     <= '0;
            end else if (rom_en) begin
                if (last_word) begin
                    word_cnt <= '0;
                    gap_cnt  <= prog_gap;
                    // Saturates so repeat-until-abort never wraps the count.
                    if (!final_pass && (pass_cnt != '1)) begin
                        pass_cnt <= pass_cnt + CNT_W'(1);
                    end
                end else begin
                    word_cnt <= word_cnt + ADDR_W'(1);
                end
            end else if ((state == GAP) && !abort) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

    stim_playback_ctrl_skid_fifo #(
        .WIDTH (DATA_W + 2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (abort),
        .entry ({rom_data, rom_strobe, inflight_last}),
        .head  (fifo_head),
        .count (fifo_count)
    );

    assign stream.out_valid  = (fifo_count != 2'd0);
    assign stream.out_data   = fifo_head[DATA_W+1:2];
    assign stream.out_strobe = fifo_head[1];
    assign stream.out_last   = fifo_head[0] && stream.out_valid;
endmodule

// File: tb/tb_stim_playback_ctrl.sv
// Self-checking bench for stim_playback_ctrl: a behavioural model lists the
// words each program must deliver; one compare process checks every transfer,
// stall stability, read credits, done and abort behaviour.
module tb_stim_playback_ctrl;

    typedef struct packed {
        logic [31:0] data;
        logic        strobe;
        logic        last;
        logic        fin;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [5:0]  cfg_base;
    logic [5:0]  cfg_len;
    logic [7:0]  cfg_repeat;
    logic [7:0]  cfg_gap;
    logic        rom_en;
    logic [5:0]  rom_addr;
    logic [31:0] rom_data = '0;
    logic        rom_strobe = 1'b0;
    logic        busy;
    logic        done;

    stim_playback_ctrl_if #(.DATA_W(32)) bus ();

    stim_playback_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .cfg_base   (cfg_base),
        .cfg_len    (cfg_len),
        .cfg_repeat (cfg_repeat),
        .cfg_gap    (cfg_gap),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .rom_strobe (rom_strobe),
        .stream     (bus),
        .busy       (busy),
        .done       (done)
    );

    int   n_checks = 0;
    int   n_err    = 0;
    exp_t exp_mem [4096];
    int   exp_wr   = 0;
    int   exp_rd   = 0;
    int   cyc      = 0;
    int   n_acc    = 0;
    int   acc_log [8192];
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   ready_mode  = 0;
    logic ready_fixed = 1'b1;

    initial forever #5 clk = ~clk;

    // Synchronous ROM: data = address, strobe = address bit 0.
    initial forever begin
        @(posedge clk);
        if (rom_en) begin
            rom_data   <= 32'(rom_addr);
            rom_strobe <= rom_addr[0];
        end
    end

    // Downstream ready: fixed level or 50% random.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : ready_fixed;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Compare process: samples on the falling edge, away from the active edge.
    initial begin
        int   outstanding = 0;
        logic stall_prev  = 1'b0;
        logic abort_prev  = 1'b0;
        logic done_due    = 1'b0;
        logic fire;
        logic [31:0] held_data = '0;
        logic held_strobe = 1'b0;
        logic held_last   = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                exp_rd      = exp_wr;
                outstanding = 0;
                stall_prev  = 1'b0;
                abort_prev  = 1'b0;
                done_due    = 1'b0;
            end else begin
                fire = bus.out_valid && bus.out_ready;
                if (abort_prev) begin
                    check("abort_valid", bus.out_valid, 0);
                    check("abort_busy", busy, 0);
                end
                if (stall_prev) begin
                    check("stall_valid", bus.out_valid, 1);
                    check("stall_data", bus.out_data, held_data);
                    check("stall_strobe", bus.out_strobe, held_strobe);
                    check("stall_last", bus.out_last, held_last);
                end
                check("done", done, done_due);
                if (rom_en) check("credit", ((outstanding - int'(fire)) < 2), 1);
                done_due = 1'b0;
                if (fire) begin
                    check("word_expected", (exp_wr != exp_rd), 1);
                    if (exp_wr != exp_rd) begin
                        e = exp_mem[exp_rd % 4096];
                        exp_rd++;
                        check("data", bus.out_data, e.data);
                        check("strobe", bus.out_strobe, e.strobe);
                        check("last", bus.out_last, e.last);
                        done_due = e.fin && !abort;
                    end
                    acc_log[n_acc % 8192] = cyc;
                    n_acc++;
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                outstanding = outstanding + int'(rom_en) - int'(fire);
                stall_prev  = bus.out_valid && !bus.out_ready && !abort;
                held_data   = bus.out_data;
                held_strobe = bus.out_strobe;
                held_last   = bus.out_last;
                abort_prev  = abort;
                if (abort) begin
                    outstanding = 0;
                    exp_rd      = exp_wr;
                    done_due    = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Append the program's words to the model, then pulse start for one edge.
    task automatic run_program(input int base, input int len, input int rep,
                               input int gap, input int inf_words);
        int passes;
        passes = (rep == 0) ? (inf_words + len) / (len + 1) : rep;
        for (int p = 0; p < passes; p++) begin
            for (int w = 0; w <= len; w++) begin
                exp_t e;
                int   a;
                a        = (base + w) % 64;
                e.data   = 32'(a);
                e.strobe = a[0];
                e.last   = (w == len);
                e.fin    = (rep != 0) && (p == rep - 1) && (w == len);
                exp_mem[exp_wr % 4096] = e;
                exp_wr++;
            end
        end
        cfg_base   = 6'(base);
        cfg_len    = 6'(len);
        cfg_repeat = 8'(rep);
        cfg_gap    = 8'(gap);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (!busy) break;
        end
        tick();
        check("idle_reached", busy, 0);
        check("words_left", 64'(exp_wr - exp_rd), 0);
    endtask

    task automatic wait_acc(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (n_acc >= target) break;
        end
        check("acc_reached", (n_acc >= target), 1);
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        int b;
        int d0;
        int base;
        int len;
        int rep;
        int gap;
        rst        = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        cfg_base   = '0;
        cfg_len    = '0;
        cfg_repeat = '0;
        cfg_gap    = '0;

        // Reset state.
        #2;
        check("rst_rom_en", rom_en, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_last", bus.out_last, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // base=4 len=3 repeat=1 gap=0: latency, back-to-back words, done timing.
        b  = n_acc;
        d0 = done_cnt;
        run_program(4, 3, 1, 0, 0);
        #1;
        check("t1_busy", busy, 1);
        check("t1_rom_en", rom_en, 1);
        check("t1_rom_addr", rom_addr, 4);
        tick();
        #1;
        check("t1_valid_k1", bus.out_valid, 0);
        tick();
        #1;
        check("t1_valid_k2", bus.out_valid, 1);
        check("t1_first", bus.out_data, 4);
        wait_idle(50);
        check("t1_count", 64'(n_acc - b), 4);
        for (int i = 1; i < 4; i++) check("t1_spacing", 64'(acc_log[b + i] - acc_log[b + i - 1]), 1);
        check("t1_done_delay", 64'(done_cyc - acc_log[b + 3]), 1);
        check("t1_done_cnt", 64'(done_cnt - d0), 1);

        // base=62 len=3 repeat=2 gap=5: address wrap and exactly 5 idle cycles.
        b  = n_acc;
        d0 = done_cnt;
        run_program(62, 3, 2, 5, 0);
        wait_idle(100);
        check("t2_count", 64'(n_acc - b), 8);
        check("t2_gap", 64'(acc_log[b + 4] - acc_log[b + 3]), 6);
        check("t2_spacing_a", 64'(acc_log[b + 3] - acc_log[b]), 3);
        check("t2_spacing_b", 64'(acc_log[b + 7] - acc_log[b + 4]), 3);
        check("t2_done_cnt", 64'(done_cnt - d0), 1);

        // Random backpressure and programs, including len=63 and len=0.
        ready_mode = 1;
        for (int t = 0; t < 5; t++) begin
            base = int'($urandom_range(0, 63));
            len  = (t == 0) ? 15 : (t == 1) ? 63 : (t == 2) ? 0 : int'($urandom_range(0, 63));
            rep  = (t == 0) ? 3 : int'($urandom_range(1, 3));
            gap  = int'($urandom_range(0, 5));
            b  = n_acc;
            d0 = done_cnt;
            run_program(base, len, rep, gap, 0);
            if (t == 0) begin
                // Second start with a different program while busy: ignored.
                repeat (6) tick();
                cfg_base   = 6'(base + 7);
                cfg_len    = 6'd2;
                cfg_repeat = 8'd9;
                cfg_gap    = 8'd1;
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            wait_idle(2000);
            check("rnd_count", 64'(n_acc - b), 64'((len + 1) * rep));
            check("rnd_done_cnt", 64'(done_cnt - d0), 1);
        end
        ready_mode  = 0;
        ready_fixed = 1'b1;

        // Repeat until abort: len=1, gap=0, abort after 20 words.
        b  = n_acc;
        d0 = done_cnt;
        run_program(0, 1, 0, 0, 64);
        wait_acc(b + 20, 100);
        pulse_abort();
        #1;
        check("t4_busy", busy, 0);
        check("t4_valid", bus.out_valid, 0);
        repeat (5) tick();
        check("t4_no_done", 64'(done_cnt - d0), 0);

        // Abort during the inter-pass gap.
        b  = n_acc;
        d0 = done_cnt;
        run_program(0, 2, 2, 8, 0);
        wait_acc(b + 3, 50);
        tick();
        tick();
        check("t5_in_gap", bus.out_valid, 0);
        pulse_abort();
        #1;
        check("t5_busy", busy, 0);
        repeat (12) tick();
        check("t5_no_done", 64'(done_cnt - d0), 0);
        check("t5_no_words", 64'(n_acc - b), 3);

        // Start and abort together in IDLE: stays IDLE, nothing plays.
        b = n_acc;
        cfg_base   = 6'd8;
        cfg_len    = 6'd3;
        cfg_repeat = 8'd1;
        cfg_gap    = 8'd0;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        #1;
        check("t6_busy", busy, 0);
        repeat (6) tick();
        check("t6_no_words", 64'(n_acc - b), 0);

        // Reset mid-pass while stalled, then a fresh start replays from base.
        ready_fixed = 1'b0;
        run_program(10, 5, 1, 0, 0);
        repeat (4) tick();
        #1;
        check("t7_valid_pre", bus.out_valid, 1);
        check("t7_data_pre", bus.out_data, 10);
        #1;
        rst = 1'b0;
        #1;
        check("t7_rom_en", rom_en, 0);
        check("t7_rom_addr", rom_addr, 0);
        check("t7_valid", bus.out_valid, 0);
        check("t7_data", bus.out_data, 0);
        check("t7_strobe", bus.out_strobe, 0);
        check("t7_last", bus.out_last, 0);
        check("t7_busy", busy, 0);
        check("t7_done", done, 0);
        tick();
        tick();
        rst = 1'b1;
        ready_fixed = 1'b1;
        tick();
        b  = n_acc;
        d0 = done_cnt;
        run_program(10, 5, 1, 0, 0);
        wait_idle(60);
        check("t7_count", 64'(n_acc - b), 6);
        check("t7_done_cnt", 64'(done_cnt - d0), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
